dcache_sa: RTL and testbench
============================

Name: dcache_sa

Overview:
Parametrised set-associative, write-back, write-allocate data cache. It sits between the pipeline memory stage and the word-wide Data_mem inside CPU, and is a drop-in successor to dcache. It generalises dcache in associativity, set count and line length, and adds dirty-line write-back, round-robin replacement and hit/miss counters.

Parameters:
ADDR_W, 16, byte-address width
WAYS, 2, associativity; power of 2, 1..4
SETS, 16, sets per way; power of 2
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
address  in  ADDR_W  byte address from the pipeline; bits [1:0] are ignored
data_in_cpu  in  32  store data
rd  in  1  load request
wr  in  4  store byte enables; nonzero means a store request
data2cpu  out  32  load data, registered
data_ready  out  1  one-cycle completion pulse
hit_miss  out  1  valid while data_ready=1: 1 = the access hit
m_rd_address  out  ADDR_W  memory read byte address (word aligned)
m_wr_address  out  ADDR_W  memory write byte address (word aligned)
mrden  out  1  memory read enable
mwren  out  1  memory write enable
data2mem  out  32  memory write data
data_in_mem  in  32  memory read data; valid the cycle after mrden
hit_count  out  16  saturating count of hits
miss_count  out  16  saturating count of misses

Behaviour:
- Address split: byte[1:0], word[log2 LINE_WORDS], index[log2 SETS], tag = the remaining upper bits.
- Per line: valid, dirty, tag, data. Per set: round-robin victim pointer.
- Reset (async): state=IDLE; all valid, dirty and victim pointers = 0; data2cpu=0; data_ready=0; hit_miss=0; mrden=0; mwren=0; addresses=0; data2mem=0; both counters=0. Data arrays are not cleared.
- Reset mid-operation aborts any fill or write-back and discards dirty data. There is no flush.
- Request rule: a request exists when rd=1 or wr!=0. If both are asserted, the access is a store. The requester holds address, data and enables stable until data_ready, and must change or drop them in the following cycle.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE:
  - Tags of all ways in the set are compared combinationally.
  - Hit: go to RESP.
  - Miss with a clean or invalid victim: go to FILL.
  - Miss with a valid dirty victim: go to WB.
- Victim selection: lowest-numbered invalid way; otherwise the set's victim pointer. The pointer increments modulo WAYS on every fill.
- WB (LINE_WORDS cycles), counter k from 0 to LINE_WORDS-1:
  - mwren=1, m_wr_address={victim tag, index, k, 2'b00}, data2mem=victim word k.
  - Afterwards clear the victim's dirty bit, then go to FILL.
- FILL (LINE_WORDS+1 cycles), counter k from 0 to LINE_WORDS:
  - While k<LINE_WORDS: mrden=1, m_rd_address={req tag, index, k, 2'b00}.
  - On each edge with k>=1: write data_in_mem into word k-1.
  - At k=LINE_WORDS: set valid=1, dirty=0, tag=req tag, then go to RESP.
- RESP (1 cycle):
  - data_ready=1.
  - Load: data2cpu = the full addressed word.
  - Store: merge data_in_cpu bytes selected by wr into the line and set dirty=1; data2cpu holds its previous value.
  - hit_miss = 1 if the access hit in IDLE, else 0.
  - Next state IDLE.
- Latency from the request cycle to data_ready:
  - hit: 1
  - clean miss: LINE_WORDS+2
  - dirty miss: 2*LINE_WORDS+2
- mrden and mwren are never asserted together.
- Outside WB and FILL: mrden=mwren=0.
- Counters: each access counts once, on entry to RESP, into hit_count or miss_count. Both saturate at 0xFFFF.

Test Plan:
- Defaults. Load 0x0040 after reset -> miss; FILL reads 0x0040, 0x0044, 0x0048, 0x004C; data_ready at cycle 6, hit_miss=0, data2cpu=mem[0x0040]. Repeat the load -> data_ready at cycle 1, hit_miss=1.
- Store 0x0044 wr=4'b0011 data=0xAABBCCDD over a cached 0x11223344 -> data_ready in 1 cycle. A following load of 0x0044 returns 0x1122CCDD; no mwren so far.
- Fill 0x0040 and 0x0140 (index 4, tags 0 and 1). Dirty 0x0040, then load 0x0240 -> write-back of 0x0040..0x004C (mwren ×4), then fill; data_ready at cycle 10; memory holds the merged word.
- Assert rst during FILL (k=2) -> all outputs are 0 immediately. The next load of the same address misses again.
- Run 3 distinct-tag clean misses on one set -> victims are way0 (invalid), way1 (invalid), then way0 via the pointer. miss_count=3 and hit_count=0.
- Assert rd=1 and wr=4'b1111 together on a hit -> treated as a store; dirty=1, data2cpu unchanged.

Source files
------------

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative write-back, write-allocate data cache between the pipeline and word-wide Data_mem.
// Latency: hit 1 cycle, clean miss LINE_WORDS+2, dirty miss 2*LINE_WORDS+2 (request cycle to data_ready).
// Backpressure: none; the requester holds address/data/enables until the data_ready pulse.
// Ports: clk/rst (async active-high); address, data_in_cpu, rd, wr (pipeline request);
//        data2cpu, data_ready, hit_miss (response); m_rd_address, m_wr_address, mrden, mwren,
//        data2mem, data_in_mem (memory side); hit_count, miss_count (saturating statistics).
module dcache_sa #(
    parameter int ADDR_W     = 16,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in_cpu,
    input  logic              rd,
    input  logic [3:0]        wr,
    output logic [31:0]       data2cpu,
    output logic              data_ready,
    output logic              hit_miss,
    output logic [ADDR_W-1:0] m_rd_address,
    output logic [ADDR_W-1:0] m_wr_address,
    output logic              mrden,
    output logic              mwren,
    output logic [31:0]       data2mem,
    input  logic [31:0]       data_in_mem,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int K_W    = WORD_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state;
    logic [K_W-1:0]   k;
    logic [WAY_W-1:0] way;      // way being hit, written back or filled
    logic             hit_q;

    logic [WAYS-1:0]  valid   [SETS];
    logic [WAYS-1:0]  dirty   [SETS];
    logic [WAY_W-1:0] rr_ptr  [SETS];
    logic [TAG_W-1:0] tag_arr [WAYS][SETS];
    logic [31:0]      data_arr[WAYS][SETS][LINE_WORDS];

    // Byte offset within the word is irrelevant to a word-wide cache.
    logic addr_unused;
    assign addr_unused = &address[1:0];

    logic [WORD_W-1:0] a_word;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    assign a_word = address[WORD_W+1:2];
    assign a_idx  = address[IDX_W+WORD_W+1:WORD_W+2];
    assign a_tag  = address[ADDR_W-1:ADDR_W-TAG_W];

    logic req, is_store;
    assign req      = rd | (|wr);
    assign is_store = |wr;          // store wins when rd and wr are both asserted

    logic              lk_hit, any_inv;
    logic [WAY_W-1:0]  lk_way, inv_way, victim;
    logic [WORD_W-1:0] k_word, fill_word;
    logic [31:0]       merged;

    assign k_word    = WORD_W'(k);
    assign fill_word = WORD_W'(k - 1'b1);

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[a_idx][w] && (tag_arr[w][a_idx] == a_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!valid[a_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim = any_inv ? inv_way : rr_ptr[a_idx];
    end

    always_comb begin
        merged = data_arr[way][a_idx][a_word];
        for (int b = 0; b < 4; b++) begin
            if (wr[b]) merged[8*b +: 8] = data_in_cpu[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            way        <= '0;
            hit_q      <= 1'b0;
            data2cpu   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                dirty[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        k <= '0;
                        if (lk_hit) begin
                            way   <= lk_way;
                            hit_q <= 1'b1;
                            state <= RESP;
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 1'b1;
                            if (!is_store) data2cpu <= data_arr[lk_way][a_idx][a_word];
                        end else begin
                            way   <= victim;
                            hit_q <= 1'b0;
                            state <= (valid[a_idx][victim] && dirty[a_idx][victim]) ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    if (k == K_W'(LINE_WORDS - 1)) begin
                        dirty[a_idx][way] <= 1'b0;
                        k                 <= '0;
                        state             <= FILL;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FILL: begin
                    if (k == K_W'(LINE_WORDS)) begin
                        valid[a_idx][way] <= 1'b1;
                        dirty[a_idx][way] <= 1'b0;
                        rr_ptr[a_idx]     <= (rr_ptr[a_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                                : rr_ptr[a_idx] + 1'b1;
                        state             <= RESP;
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
                        // The last line word lands in the array on this same edge, so forward it.
                        if (!is_store)
                            data2cpu <= (a_word == WORD_W'(LINE_WORDS - 1)) ? data_in_mem
                                                                            : data_arr[way][a_idx][a_word];
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    if (is_store) dirty[a_idx][way] <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (state == FILL && k != '0) data_arr[way][a_idx][fill_word] <= data_in_mem;
        if (state == FILL && k == K_W'(LINE_WORDS)) tag_arr[way][a_idx] <= a_tag;
        if (state == RESP && is_store) data_arr[way][a_idx][a_word] <= merged;
    end

    assign data_ready = (state == RESP);
    assign hit_miss   = (state == RESP) && hit_q;

    always_comb begin
        mrden        = 1'b0;
        mwren        = 1'b0;
        m_rd_address = '0;
        m_wr_address = '0;
        data2mem     = '0;
        if (state == WB) begin
            mwren        = 1'b1;
            m_wr_address = {tag_arr[way][a_idx], a_idx, k_word, 2'b00};
            data2mem     = data_arr[way][a_idx][k_word];
        end
        if (state == FILL && k != K_W'(LINE_WORDS)) begin
            mrden        = 1'b1;
            m_rd_address = {a_tag, a_idx, k_word, 2'b00};
        end
    end
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed scoreboard bench for dcache_sa with a word-wide memory model.
// Stimulus pushes expected responses; a negedge monitor pops and compares on data_ready.
module tb_dcache_sa;
    logic        clk, rst;
    logic [15:0] address;
    logic [31:0] data_in_cpu;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] data2cpu;
    logic        data_ready, hit_miss;
    logic [15:0] m_rd_address, m_wr_address;
    logic        mrden, mwren;
    logic [31:0] data2mem;
    logic [31:0] data_in_mem = 32'h0;
    logic [15:0] hit_count, miss_count;

    dcache_sa dut (
        .clk(clk), .rst(rst), .address(address), .data_in_cpu(data_in_cpu),
        .rd(rd), .wr(wr), .data2cpu(data2cpu), .data_ready(data_ready),
        .hit_miss(hit_miss), .m_rd_address(m_rd_address), .m_wr_address(m_wr_address),
        .mrden(mrden), .mwren(mwren), .data2mem(data2mem), .data_in_mem(data_in_mem),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        hit;
        int          lat;
        int          t0;
        int          id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0, fails = 0, cyc = 0, n_acc = 0, overlap = 0;
    logic [31:0] mem [int];
    logic [15:0] rdq[$], wrq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Untouched words read as 0xC0DE0000 | word index; word 0x11 (byte 0x44) is preset.
    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        if (a == 17) return 32'h11223344;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mrden) data_in_mem <= mem_rd(int'(m_rd_address[15:2]));
        if (mwren) mem[int'(m_wr_address[15:2])] = data2mem;
    end

    always @(negedge clk) begin
        if (mrden && mwren) overlap++;
        if (mrden) rdq.push_back(m_rd_address);
        if (mwren) wrq.push_back(m_wr_address);
        if (!rst && data_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: data2cpu=%h with no access outstanding", data2cpu);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("acc%0d_hit", mon_e.id), 32'(hit_miss), 32'(mon_e.hit));
                check($sformatf("acc%0d_data", mon_e.id), data2cpu, mon_e.data);
                check($sformatf("acc%0d_latency", mon_e.id), cyc - mon_e.t0, mon_e.lat);
            end
        end
    end

    task automatic access(input logic [15:0] a, input logic r, input logic [3:0] w,
                          input logic [31:0] d, input logic [31:0] ed, input logic eh,
                          input int el);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        e.data = ed; e.hit = eh; e.lat = el; e.t0 = cyc; e.id = n_acc;
        n_acc++;
        sb.push_back(e);
        address = a; rd = r; wr = w; data_in_cpu = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_ready && n < 40);
        if (!data_ready) begin
            tests++;
            fails++;
            $display("FAIL acc%0d_timeout: data_ready=0 after %0d cycles, required 1", e.id, n);
            sb.delete();
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 4'b0000;
    endtask

    task automatic check_zero(input string t);
        check({t, "_data2cpu"}, data2cpu, 0);
        check({t, "_data_ready"}, 32'(data_ready), 0);
        check({t, "_hit_miss"}, 32'(hit_miss), 0);
        check({t, "_mrden"}, 32'(mrden), 0);
        check({t, "_mwren"}, 32'(mwren), 0);
        check({t, "_m_rd_address"}, 32'(m_rd_address), 0);
        check({t, "_m_wr_address"}, 32'(m_wr_address), 0);
        check({t, "_data2mem"}, data2mem, 0);
        check({t, "_hit_count"}, 32'(hit_count), 0);
        check({t, "_miss_count"}, 32'(miss_count), 0);
    endtask

    initial begin
        int base;
        rst = 1'b0; rd = 1'b0; wr = 4'b0000; address = '0; data_in_cpu = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Cold miss on 0x0040, then a hit on the same word.
        base = rdq.size();
        access(16'h0040, 1'b1, 4'b0000, 32'h0, 32'hC0DE0010, 1'b0, 6);
        check("fill_read_count", rdq.size() - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fill_read_addr%0d", i), 32'(rdq[base+i]), 32'h40 + 4*i);
        access(16'h0040, 1'b1, 4'b0000, 32'h0, 32'hC0DE0010, 1'b1, 1);

        // Partial store hit; data2cpu keeps the previous load value.
        access(16'h0044, 1'b0, 4'b0011, 32'hAABBCCDD, 32'hC0DE0010, 1'b1, 1);
        access(16'h0044, 1'b1, 4'b0000, 32'h0, 32'h1122CCDD, 1'b1, 1);
        check("no_writeback_yet", wrq.size(), 0);

        // Second way of set 4, then a third tag forces write-back of dirty way 0.
        access(16'h0140, 1'b1, 4'b0000, 32'h0, 32'hC0DE0050, 1'b0, 6);
        base = wrq.size();
        access(16'h0240, 1'b1, 4'b0000, 32'h0, 32'hC0DE0090, 1'b0, 10);
        check("wb_count", wrq.size() - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("wb_addr%0d", i), 32'(wrq[base+i]), 32'h40 + 4*i);
        check("wb_merged_word", mem_rd(17), 32'h1122CCDD);
        check("wb_word0", mem_rd(16), 32'hC0DE0010);
        check("hits_after_wb", 32'(hit_count), 3);
        check("misses_after_wb", 32'(miss_count), 3);

        // Reset while the fill is at k=2.
        @(posedge clk); #1;
        address = 16'h0080; rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fill_k2_mrden", 32'(mrden), 1);
        check("fill_k2_addr", 32'(m_rd_address), 32'h0088);
        rst = 1'b1;
        #1;
        check_zero("midfill_reset");
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        access(16'h0080, 1'b1, 4'b0000, 32'h0, 32'hC0DE0020, 1'b0, 6);
        check("misses_after_abort", 32'(miss_count), 1);
        check("hits_after_abort", 32'(hit_count), 0);

        // Three tags into set 2: way0, way1, then way0 again by the pointer.
        @(posedge clk); #1;
        rst = 1'b1;
        #2 rst = 1'b0;
        access(16'h0020, 1'b1, 4'b0000, 32'h0, 32'hC0DE0008, 1'b0, 6);
        access(16'h0120, 1'b1, 4'b0000, 32'h0, 32'hC0DE0048, 1'b0, 6);
        access(16'h022C, 1'b1, 4'b0000, 32'h0, 32'hC0DE008B, 1'b0, 6);
        check("rr_miss_count", 32'(miss_count), 3);
        check("rr_hit_count", 32'(hit_count), 0);
        access(16'h0120, 1'b1, 4'b0000, 32'h0, 32'hC0DE0048, 1'b1, 1);
        access(16'h0020, 1'b1, 4'b0000, 32'h0, 32'hC0DE0008, 1'b0, 6);

        // rd and wr together on a hit act as a store, leaving the line dirty.
        access(16'h022C, 1'b1, 4'b1111, 32'hDEADBEEF, 32'hC0DE0008, 1'b1, 1);
        base = wrq.size();
        access(16'h0320, 1'b1, 4'b0000, 32'h0, 32'hC0DE00C8, 1'b0, 10);
        check("rdwr_wb_count", wrq.size() - base, 4);
        check("rdwr_wb_first_addr", 32'(wrq[base]), 32'h0220);
        check("rdwr_stored_word", mem_rd(32'h8B), 32'hDEADBEEF);
        check("rdwr_clean_word", mem_rd(32'h88), 32'hC0DE0088);

        check("rd_wr_overlap", overlap, 0);
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule
